// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode constants, FSM encoding and decode helpers shared by
//                the EX-stage ALU, its decoder and the pipeline control.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_SRA   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op >= OP_MUL);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Unsigned restoring divider, one quotient bit per step_i.
//  Revision    : 1.0  initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // A zero divisor never underflows, giving all-ones quotient and remainder = dividend.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : iter_alu
//  Description : EX-stage ALU; single-cycle base ops, bit-serial MUL/DIV/REM.
//  Revision    : 1.0  initial release
// ============================================================================
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   single_res, fix_res, quo, rem;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic               signed_op, a_neg, b_neg, div_start, div_step;
    logic [SHW-1:0]     shamt;

    assign shamt     = B_i[SHW-1:0];
    assign signed_op = (ALU_Operation_i == OP_DIV) || (ALU_Operation_i == OP_REM);
    assign a_neg     = signed_op && A_i[WIDTH-1];
    assign b_neg     = signed_op && B_i[WIDTH-1];
    assign abs_a     = a_neg ? -A_i : A_i;
    assign abs_b     = b_neg ? -B_i : B_i;
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        single_res = '0;
        case (ALU_Operation_i)
            OP_ADD:  single_res = A_i + B_i;
            OP_SUB:  single_res = A_i - B_i;
            OP_OR:   single_res = A_i | B_i;
            OP_SLL:  single_res = A_i << shamt;
            OP_SRL:  single_res = A_i >> shamt;
            OP_SRA:  single_res = $signed(A_i) >>> shamt;
            OP_AND:  single_res = A_i & B_i;
            OP_XOR:  single_res = A_i ^ B_i;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, A_i < B_i};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:            fix_res = prod_q[WIDTH-1:0];
            OP_MULHU:          fix_res = prod_q[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   fix_res = neg_quo_q ? -quo : quo;
            OP_REM, OP_REMU:   fix_res = neg_rem_q ? -rem : rem;
            default:           fix_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (is_iterative(ALU_Operation_i)) begin
                        op_d      = ALU_Operation_i;
                        cnt_d     = CNTW'(WIDTH);
                        mcand_d   = A_i;
                        prod_d    = {{WIDTH{1'b0}}, B_i};
                        // Divide-by-zero keeps the all-ones quotient regardless of sign.
                        neg_quo_d = (a_neg ^ b_neg) && (B_i != '0);
                        neg_rem_d = a_neg;
                        div_start = !is_mul(ALU_Operation_i);
                        state_d   = is_mul(ALU_Operation_i) ? ST_MUL : ST_DIV;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = fix_res;
                zero_d   = (fix_res == '0);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
        end
    end

    iter_divider #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start),
        .step_i      (div_step),
        .dividend_i  (abs_a),
        .divisor_i   (abs_b),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    assign ready_o      = (state_q == ST_IDLE);
    assign valid_o      = valid_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;

endmodule
`default_nettype wire

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, sequential successor to the single-cycle datapath ALU.
- Executes base integer ops with a 1-cycle registered latency, and multiply/divide/remainder (RV32M subset) iteratively, one bit per cycle.
- Sits in the EX stage behind a valid/ready handshake; the control unit stalls the pipeline while ready_o is low.

Parameters:
WIDTH  32  operand/result width in bits; must be even and >= 8
SHW  $clog2(WIDTH)  shift-amount width; derived, not overridable

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
valid_i  input  1  operation request; accepted when valid_i && ready_o
ALU_Operation_i  input  4  opcode (see Behaviour)
A_i  input  WIDTH  operand A
B_i  input  WIDTH  operand B / immediate
ready_o  output  1  block can accept a request this cycle
valid_o  output  1  one-cycle pulse; ALU_Result_o/Zero_o valid
ALU_Result_o  output  WIDTH  registered result, held until next valid_o
Zero_o  output  1  registered (ALU_Result_o == 0), updated with valid_o

Behaviour:
- Reset (async, active-high): state=IDLE, ready_o=1, valid_o=0, ALU_Result_o=0, Zero_o=1, counter=0. Reset mid-iteration aborts the operation; no valid_o is produced for it.
- Opcodes:
  - Single-cycle: 0 ADD, 1 SUB, 2 OR, 3 SLL, 4 SRL, 5 SRA, 6 AND, 7 XOR, 8 SLT (signed), 9 SLTU.
  - Iterative: 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Shifts use B_i[SHW-1:0] only. SLT/SLTU return 1 or 0, zero-extended.
- All arithmetic wraps modulo 2^WIDTH.
- FSM states are IDLE, MUL, DIV, FIX.
  - IDLE: ready_o=1.
  - Accepting a single-cycle op: the result is registered at the accepting edge, valid_o=1 in the next cycle, state stays IDLE. Back-to-back requests are accepted every cycle.
  - Accepting an iterative op: latch operands and op, load counter=WIDTH, go to MUL or DIV. ready_o=0 from the next cycle.
  - MUL: shift-add on a 2*WIDTH product register, one bit per cycle, counter decrements; at counter==1 go to FIX.
  - DIV: restoring divide on unsigned magnitudes. Signed ops take |A|, |B| and record sign flags at accept. One quotient bit per cycle; at counter==1 go to FIX.
  - FIX (1 cycle): select low/high word or quotient/remainder and apply sign correction. Quotient is negated if sign(A)!=sign(B); remainder takes the sign of A. Register the result and Zero_o, pulse valid_o, return to IDLE. ready_o=1 in the cycle valid_o is high.
- Iterative latency: valid_o is high exactly WIDTH+1 edges after the accepting edge (WIDTH iteration cycles + FIX). Latency is fixed regardless of operand values.
- Divide by zero (RISC-V semantics, full latency):
  - DIV/DIVU return all ones.
  - REM/REMU return A.
- Signed overflow (A = most-negative, B = -1):
  - DIV returns A.
  - REM returns 0.
  - The normal datapath with its 2's-complement wrap already produces these results; the bench checks them explicitly.
- valid_i while ready_o=0 is ignored. The operands need not be held; they are latched at accept.
- Output registers hold their value between valid_o pulses.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD..REMU), FSM state encoding, and function is_iterative(op).
- The existing ALU decoder and the pipeline control import the same opcode constants.
- One sub-module, iter_divider: unsigned restoring divider core with start/counter-done interface, WIDTH parameter, quotient and remainder outputs.
- The multiplier stays inline: shift-add is only a few lines.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 accepted at edge N -> valid_o at N+1, result 0x80000000, Zero_o=0. Then SUB 5-5 on consecutive cycles -> result 0, Zero_o=1 at N+2.
- SRA 0x80000000 by B=0x24 (uses 4) -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT same operands -> 0.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> result 1. MULHU same -> 0xFFFFFFFE. valid_o exactly 33 edges after accept; ready_o low throughout; extra valid_i pulses are ignored.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each with 33-cycle latency.
- Assert reset 10 cycles into a DIV -> outputs return immediately to reset values, no valid_o. The next ADD 2+3 after release yields 5 one cycle after accept.
